// File: rtl/umips_dmem_ctrl.sv
// umips_dmem_ctrl
// Memory-stage controller for the uMIPS pipeline. It turns the EX/MEM
// load/store controls into one request on a simple ack-based data bus,
// stalls the upstream pipeline while that request is in flight, extracts and
// extends load data, and drives the MEM/WB pipeline register.
//
// Ports
//   clk, rst        : pipeline clock (rising edge), asynchronous active-low reset
//   inst_m .. write_reg_m : memory-stage controls and operands from EX/MEM
//   dmem_req/we/addr/be/wdata : registered bus request (word-aligned address,
//                       byte-lane enables, lane-replicated store data)
//   dmem_rdata, dmem_ack : bus read data and one-cycle completion pulse
//   stall_m         : holds EX/MEM and every upstream stage
//   inst_w, reg_write_w, write_reg_w, result_w, misalign_w : MEM/WB register
module umips_dmem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_m,
    input  logic        reg_write_m,
    input  logic        mem_write_m,
    input  logic        mem_to_reg_m,
    input  logic        sign_sel_m,
    input  logic        byte_sel_m,
    input  logic        word_sel_m,
    input  logic [31:0] alu_out_m,
    input  logic [31:0] write_data_m,
    input  logic [4:0]  write_reg_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_m,
    output logic [31:0] inst_w,
    output logic        reg_write_w,
    output logic [4:0]  write_reg_w,
    output logic [31:0] result_w,
    output logic        misalign_w
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_next;
    logic        mem_op;
    logic        misaligned;
    logic        start;
    logic [1:0]  off;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rdata_q;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [31:0] result;

    assign off    = alu_out_m[1:0];
    assign mem_op = mem_write_m | mem_to_reg_m;

    // Byte select takes priority if both size selects are set.
    always_comb begin
        misaligned = 1'b0;
        if (byte_sel_m) begin
            misaligned = 1'b0;
        end else if (word_sel_m) begin
            misaligned = (off != 2'b00);
        end else begin
            misaligned = off[0];
        end
    end

    assign start = (state == IDLE) && mem_op && !misaligned;

    // The stall is gated by reset so every output reads 0 while reset is held.
    assign stall_m = rst && (start || (state == REQ));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = REQ;
            REQ:     if (dmem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Lane enables and replicated store data for the addressed size.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = write_data_m;
        if (byte_sel_m) begin
            be_calc    = 4'b0001 << off;
            wdata_calc = {4{write_data_m[7:0]}};
        end else if (!word_sel_m) begin
            be_calc    = off[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{write_data_m[15:0]}};
        end
    end

    // Bus request fields are frozen at issue so they stay stable until ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
            rdata_q    <= 32'h0;
        end else if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_m;
            dmem_addr  <= {alu_out_m[31:2], 2'b00};
            dmem_be    <= be_calc;
            dmem_wdata <= wdata_calc;
        end else if ((state == REQ) && dmem_ack) begin
            dmem_req <= 1'b0;
            rdata_q  <= dmem_rdata;
        end
    end

    // The EX/MEM register is held during the access, so the offset and size
    // seen in DONE still describe the load that captured rdata_q.
    always_comb begin
        lane_byte = 8'h00;
        case (off)
            2'd0:    lane_byte = rdata_q[7:0];
            2'd1:    lane_byte = rdata_q[15:8];
            2'd2:    lane_byte = rdata_q[23:16];
            default: lane_byte = rdata_q[31:24];
        endcase
        lane_half = off[1] ? rdata_q[31:16] : rdata_q[15:0];
        if (byte_sel_m) begin
            load_val = sign_sel_m ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
        end else if (word_sel_m) begin
            load_val = rdata_q;
        end else begin
            load_val = sign_sel_m ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
        end
    end

    // A misaligned load never reaches the bus; it passes the address through.
    assign result = (mem_to_reg_m && !misaligned) ? load_val : alu_out_m;

    // MEM/WB register: loads the op when not stalled, otherwise a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_w      <= 32'h0;
            reg_write_w <= 1'b0;
            write_reg_w <= 5'h0;
            result_w    <= 32'h0;
            misalign_w  <= 1'b0;
        end else if (!stall_m) begin
            inst_w      <= inst_m;
            reg_write_w <= reg_write_m && !(mem_op && misaligned);
            write_reg_w <= write_reg_m;
            result_w    <= result;
            misalign_w  <= mem_op && misaligned;
        end else begin
            inst_w      <= 32'h0;
            reg_write_w <= 1'b0;
            write_reg_w <= 5'h0;
            result_w    <= 32'h0;
            misalign_w  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_umips_dmem_ctrl.sv
// Bench for umips_dmem_ctrl: a transaction-level model of the memory stage
// checked against the DUT every cycle, directed scenarios with literal
// expectations, a mid-access reset, and a randomized op stream.
module tb_umips_dmem_ctrl;

    typedef struct {
        logic [31:0] inst;
        logic        rw, mw, mtr, sgn, bsel, wsel;
        logic [31:0] alu, wd;
        logic [4:0]  wreg;
        int          delay;
        logic [31:0] rdata;
        logic        spur;
        int          tag;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_m = 32'h0;
    logic        reg_write_m = 1'b0, mem_write_m = 1'b0, mem_to_reg_m = 1'b0;
    logic        sign_sel_m = 1'b0, byte_sel_m = 1'b0, word_sel_m = 1'b0;
    logic [31:0] alu_out_m = 32'h0, write_data_m = 32'h0;
    logic [4:0]  write_reg_m = 5'h0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_ack = 1'b0;
    logic        stall_m;
    logic [31:0] inst_w, result_w;
    logic        reg_write_w, misalign_w;
    logic [4:0]  write_reg_w;

    always #5 clk = ~clk;

    umips_dmem_ctrl dut (
        .clk(clk), .rst(rst),
        .inst_m(inst_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .mem_to_reg_m(mem_to_reg_m), .sign_sel_m(sign_sel_m),
        .byte_sel_m(byte_sel_m), .word_sel_m(word_sel_m),
        .alu_out_m(alu_out_m), .write_data_m(write_data_m), .write_reg_m(write_reg_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_m(stall_m),
        .inst_w(inst_w), .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
        .result_w(result_w), .misalign_w(misalign_w)
    );

    int checks = 0;
    int failures = 0;

    op_t q[$];
    op_t cur;
    op_t nop;
    int  wait_cnt = 0;

    // Model: an access is outstanding (pending) from the cycle after it is
    // presented until the cycle ack is seen; it is finished for one cycle after.
    bit          pending = 0, finished = 0, consumed = 1;
    logic [31:0] e_addr = 0, e_wdata = 0, cap = 0;
    logic [3:0]  e_be = 0;
    logic        e_we = 0;
    logic [31:0] e_inst = 0, e_res = 0;
    logic        e_rw = 0, e_mis = 0;
    logic [4:0]  e_wreg = 0;

    logic [31:0] m_res[256], m_addr[256], m_wdata[256];
    logic [3:0]  m_be[256];
    logic        m_mis[256], m_we[256], m_rw[256];
    logic [4:0]  m_wreg[256];
    int          stall_cnt[256], req_cnt[256];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [31:0] w, input int o, input int n, input logic sgn);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = w[8*(o+k) +: 8];
        if (sgn && n < 4 && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic op_t make_op(input int tag, input int kind, input int size, input logic [31:0] addr,
                                    input logic sgn, input logic [31:0] wd, input int delay, input logic [31:0] rd);
        op_t o;
        o.inst = $urandom; o.rw = (kind != 2); o.mw = (kind == 2); o.mtr = (kind == 1);
        o.sgn = sgn; o.bsel = (size == 1); o.wsel = (size == 4);
        o.alu = addr; o.wd = wd; o.wreg = 5'($urandom_range(1, 31));
        o.delay = delay; o.rdata = rd; o.spur = 1'b1; o.tag = tag;
        return o;
    endfunction

    task automatic apply_stimulus(input op_t o);
        q.push_back(o);
    endtask

    task automatic drive_inputs(input op_t o);
        inst_m = o.inst; reg_write_m = o.rw; mem_write_m = o.mw; mem_to_reg_m = o.mtr;
        sign_sel_m = o.sgn; byte_sel_m = o.bsel; word_sel_m = o.wsel;
        alu_out_m = o.alu; write_data_m = o.wd; write_reg_m = o.wreg;
    endtask

    // One pipeline cycle: advance the EX/MEM source when the op was consumed
    // and play the memory side (delayed ack, occasional spurious ack).
    task automatic step();
        @(posedge clk);
        #2;
        if (consumed) begin
            if (q.size() > 0) cur = q.pop_front();
            else cur = nop;
            wait_cnt = 0;
        end
        drive_inputs(cur);
        if (pending) begin
            dmem_ack = (wait_cnt == cur.delay);
            wait_cnt++;
        end else begin
            dmem_ack = cur.spur && ($urandom_range(0, 1) == 1);
        end
        dmem_rdata = (pending && dmem_ack) ? cur.rdata : $urandom;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (!(q.size() == 0 && cur.tag == 255 && consumed) && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d required<%0d", n, limit);
        end
        step();
        step();
    endtask

    // Compare process: mid-cycle, check the DUT against the model, then
    // advance the model across the coming rising edge.
    always @(negedge clk) begin
        int          nbytes, o;
        bit          is_mem, mis, e_stall;
        if (!rst) begin
            check_output("rst_req", dmem_req, 0);
            check_output("rst_be", dmem_be, 0);
            check_output("rst_stall", stall_m, 0);
            check_output("rst_reg_write_w", reg_write_w, 0);
            check_output("rst_result_w", result_w, 0);
            check_output("rst_inst_w", inst_w, 0);
            check_output("rst_misalign_w", misalign_w, 0);
            pending = 0; finished = 0; consumed = 1;
            e_inst = 0; e_rw = 0; e_wreg = 0; e_res = 0; e_mis = 0;
        end else begin
            nbytes  = byte_sel_m ? 1 : (word_sel_m ? 4 : 2);
            o       = int'(alu_out_m[1:0]);
            is_mem  = mem_write_m || mem_to_reg_m;
            mis     = (o % nbytes) != 0;
            e_stall = is_mem && !mis && !finished;

            check_output("stall_m", stall_m, e_stall);
            check_output("dmem_req", dmem_req, pending);
            if (pending) begin
                check_output("dmem_addr", dmem_addr, e_addr);
                check_output("dmem_we", dmem_we, e_we);
                check_output("dmem_be", dmem_be, e_be);
                check_output("dmem_wdata", dmem_wdata, e_wdata);
            end
            check_output("inst_w", inst_w, e_inst);
            check_output("reg_write_w", reg_write_w, e_rw);
            check_output("write_reg_w", write_reg_w, e_wreg);
            check_output("result_w", result_w, e_res);
            check_output("misalign_w", misalign_w, e_mis);

            if (e_stall) stall_cnt[cur.tag]++;
            if (pending) req_cnt[cur.tag]++;

            if (!e_stall) begin
                e_inst = inst_m;
                e_mis  = is_mem && mis;
                e_rw   = reg_write_m && !e_mis;
                e_wreg = write_reg_m;
                e_res  = (mem_to_reg_m && !mis) ? load_value(cap, o, nbytes, sign_sel_m) : alu_out_m;
                m_res[cur.tag] = e_res; m_mis[cur.tag] = e_mis;
                m_rw[cur.tag] = e_rw; m_wreg[cur.tag] = e_wreg;
                finished = 0;
                consumed = 1;
            end else begin
                e_inst = 0; e_rw = 0; e_wreg = 0; e_res = 0; e_mis = 0;
                consumed = 0;
            end

            if (pending) begin
                if (dmem_ack) begin
                    pending  = 0;
                    finished = 1;
                    cap      = dmem_rdata;
                end
            end else if (e_stall) begin
                pending = 1;
                e_addr  = {alu_out_m[31:2], 2'b00};
                e_we    = mem_write_m;
                e_be    = 4'b0000;
                for (int k = 0; k < nbytes; k++) e_be[o+k] = 1'b1;
                for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = write_data_m[8*(i % nbytes) +: 8];
                m_addr[cur.tag] = e_addr; m_be[cur.tag] = e_be;
                m_wdata[cur.tag] = e_wdata; m_we[cur.tag] = e_we;
            end
        end
    end

    initial begin
        op_t o;
        int  n, kind, sz;
        logic [31:0] a;

        nop = '{default: 0};
        nop.tag = 255;
        cur = nop;
        for (int i = 0; i < 256; i++) begin
            stall_cnt[i] = 0; req_cnt[i] = 0;
        end
        drive_inputs(nop);

        #1 rst = 1'b0;
        #2;
        check_output("reset_dmem_req", dmem_req, 0);
        check_output("reset_dmem_addr", dmem_addr, 0);
        check_output("reset_dmem_wdata", dmem_wdata, 0);
        check_output("reset_write_reg_w", write_reg_w, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // Directed scenarios, tags 0..6
        o = make_op(0, 0, 4, 32'h0000_1234, 0, 0, 0, 0);
        o.wreg = 5'd5;
        apply_stimulus(o);
        apply_stimulus(make_op(1, 1, 1, 32'h0000_1003, 1, 0, 0, 32'h80FF_FFFF));
        apply_stimulus(make_op(2, 1, 1, 32'h0000_1003, 0, 0, 0, 32'h80FF_FFFF));
        apply_stimulus(make_op(3, 2, 2, 32'h0000_2002, 0, 32'hAAAA_BEEF, 2, 0));
        apply_stimulus(make_op(4, 1, 4, 32'h0000_3001, 0, 0, 0, 0));
        apply_stimulus(make_op(5, 1, 4, 32'h0000_4000, 0, 0, 0, 32'h1111_2222));
        apply_stimulus(make_op(6, 1, 4, 32'h0000_4004, 0, 0, 0, 32'h3333_4444));
        drain(200);

        check_output("alu_result", m_res[0], 32'h0000_1234);
        check_output("alu_write_reg", m_wreg[0], 5);
        check_output("alu_stall_cycles", stall_cnt[0], 0);
        check_output("lb_be", m_be[1], 4'b1000);
        check_output("lb_addr", m_addr[1], 32'h0000_1000);
        check_output("lb_signed_result", m_res[1], 32'hFFFF_FF80);
        check_output("lb_stall_cycles", stall_cnt[1], 2);
        check_output("lbu_result", m_res[2], 32'h0000_0080);
        check_output("sh_be", m_be[3], 4'b1100);
        check_output("sh_wdata", m_wdata[3], 32'hBEEF_BEEF);
        check_output("sh_we", m_we[3], 1);
        check_output("sh_req_cycles", req_cnt[3], 3);
        check_output("sh_stall_cycles", stall_cnt[3], 4);
        check_output("lw_mis_flag", m_mis[4], 1);
        check_output("lw_mis_reg_write", m_rw[4], 0);
        check_output("lw_mis_req_cycles", req_cnt[4], 0);
        check_output("lw_mis_stall_cycles", stall_cnt[4], 0);
        check_output("b2b_first_req", req_cnt[5], 1);
        check_output("b2b_second_req", req_cnt[6], 1);
        check_output("b2b_first_result", m_res[5], 32'h1111_2222);
        check_output("b2b_second_result", m_res[6], 32'h3333_4444);

        // Reset while a request is outstanding
        apply_stimulus(make_op(7, 1, 4, 32'h0000_5000, 0, 0, 50, 32'h1));
        n = 0;
        while (!pending && n < 20) begin
            step();
            n++;
        end
        check_output("abort_reached_req", dmem_req, 1);
        rst = 1'b0;
        #1;
        check_output("abort_req_drop", dmem_req, 0);
        check_output("abort_be", dmem_be, 0);
        check_output("abort_stall", stall_m, 0);
        check_output("abort_reg_write_w", reg_write_w, 0);
        cur = nop;
        drive_inputs(nop);
        @(negedge clk);
        #1;
        rst = 1'b1;
        dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        check_output("spurious_ack_req", dmem_req, 0);
        check_output("spurious_ack_stall", stall_m, 0);
        check_output("abort_no_writeback", reg_write_w, 0);

        // Randomized op stream
        for (int t = 8; t < 200; t++) begin
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0:       sz = 1;
                1:       sz = 2;
                default: sz = 4;
            endcase
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 4) a[1:0] = 2'b00;
                else if (sz == 2) a[0] = 1'b0;
            end
            o = make_op(t, kind, sz, a, 1'($urandom_range(0, 1)), $urandom,
                        $urandom_range(0, 3), $urandom);
            o.rw = 1'($urandom_range(0, 1));
            o.spur = 1'($urandom_range(0, 1));
            apply_stimulus(o);
        end
        drain(5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
